// File: rtl/uart_receiver.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a rdy/rd_en byte handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches on parity_err.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,  // clken ticks per bit; even and >= 4
    parameter int SYNC_STAGES = 2    // rx synchroniser depth; >= 2
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       clken,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] SCNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SCNT_LAST = CW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [CW-1:0]          scnt_q, scnt_d;
    logic [2:0]             bitpos_q, bitpos_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   load;
    logic                   fe_set;
`ifdef UART_RX_PARITY_EN
    logic                   pe_set;
`endif

    // Presetting to 1 keeps reset release from looking like a start bit.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        scnt_d   = scnt_q;
        bitpos_d = bitpos_q;
        shreg_d  = shreg_q;
        load     = 1'b0;
        fe_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_set   = 1'b0;
`endif
        if (clken) begin
            scnt_d = scnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        scnt_d  = '0;
                    end
                end
                START: begin
                    if (scnt_q == SCNT_MID) begin
                        scnt_d = '0;
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            bitpos_d = '0;
                            state_d  = DATA;
                        end
                    end
                end
                DATA: begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d           = '0;
                        shreg_d[bitpos_q] = rxs;
                        bitpos_d         = bitpos_q + 1'b1;
                        if (bitpos_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d  = '0;
                        pe_set  = (rxs != ^shreg_q);
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    // Mid-bit of the stop bit: one bit period after the last data/parity sample.
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = '0;
                        if (rxs) begin
                            load    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            fe_set  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            scnt_q    <= '0;
            bitpos_q  <= '0;
            shreg_q   <= '0;
            dout      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bitpos_q  <= bitpos_d;
            shreg_q   <= shreg_d;
            frame_err <= fe_set;
            // A completing byte takes priority over the host acknowledge.
            if (load) begin
                dout <= shreg_q;
                rdy  <= 1'b1;
                if (rdy && !rd_en) begin
                    overrun <= 1'b1;
                end
            end else if (rd_en) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= pe_set;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16, one clken tick every 4 system_clk cycles.
module tb_uart_receiver;

    logic       system_clk;
    logic       reset;
    logic       clken;
    logic       rx;
    logic       rd_en;
    logic [7:0] dout;
    logic       rdy;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks   = 0;
    int errors   = 0;
    int fe_count = 0;
    int pe_count = 0;
`ifdef UART_RX_PARITY_EN
    logic bad_parity = 1'b0;
`endif

    uart_receiver #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .system_clk(system_clk),
        .reset     (reset),
        .clken     (clken),
        .rx        (rx),
        .rd_en     (rd_en),
        .dout      (dout),
        .rdy       (rdy),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial begin
        system_clk = 1'b0;
        forever #5 system_clk = ~system_clk;
    end

    // Pulse counters, sampled mid-cycle; each one-cycle pulse is seen exactly once.
    always @(negedge system_clk) begin
        if (frame_err)  fe_count++;
        if (parity_err) pe_count++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One oversample tick: 3 idle cycles then a cycle with clken high. Entered and left on a negedge.
    task automatic tick(input logic ack);
        clken = 1'b0;
        rd_en = 1'b0;
        repeat (3) @(negedge system_clk);
        clken = 1'b1;
        rd_en = ack;
        @(negedge system_clk);
        clken = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // The receiver decides on tick 8 of a bit; ack_mid puts rd_en on exactly that cycle.
    task automatic send_bit(input logic b, input logic ack_mid);
        rx = b;
        for (int i = 0; i < 16; i++) tick(ack_mid && (i == 8));
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic ack_at_load);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i], 1'b0);
`ifdef UART_RX_PARITY_EN
        send_bit(^data ^ bad_parity, 1'b0);
`endif
        send_bit(stop_bit, ack_at_load);
    endtask

    task automatic ack();
        rd_en = 1'b1;
        @(negedge system_clk);
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clken = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (2) @(negedge system_clk);
        check("reset_dout",       32'(dout),       32'h0);
        check("reset_rdy",        32'(rdy),        32'h0);
        check("reset_busy",       32'(rx_busy),    32'h0);
        check("reset_frame_err",  32'(frame_err),  32'h0);
        check("reset_overrun",    32'(overrun),    32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        reset = 1'b0;
        ticks(4);

        // Basic reception and handshake.
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_dout",      32'(dout),      32'hA5);
        check("a5_rdy",       32'(rdy),       32'h1);
        check("a5_frame_err", 32'(fe_count),  32'h0);
        check("a5_busy",      32'(rx_busy),   32'h0);
        ack();
        check("a5_rdy_ack",   32'(rdy),       32'h0);

        // Short low glitch is rejected at the mid-start sample.
        rx = 1'b0;
        ticks(3);
        check("glitch_busy_in",  32'(rx_busy), 32'h1);
        rx = 1'b1;
        ticks(8);
        check("glitch_busy_out", 32'(rx_busy), 32'h0);
        check("glitch_rdy",      32'(rdy),     32'h0);

        // Bad stop bit followed by a long break: one frame_err, recovery only once rx is high.
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        ticks(640);
        check("break_fe_count", 32'(fe_count), 32'h1);
        check("break_rdy",      32'(rdy),      32'h0);
        check("break_dout",     32'(dout),     32'hA5);
        check("break_busy",     32'(rx_busy),  32'h1);
        rx = 1'b1;
        ticks(16);
        check("break_release",  32'(rx_busy),  32'h0);
        send_frame(8'h81, 1'b1, 1'b0);
        check("after_break_dout", 32'(dout), 32'h81);
        check("after_break_rdy",  32'(rdy),  32'h1);
        ack();

        // Overrun: two bytes without acknowledge.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_dout",    32'(dout),    32'h22);
        check("ovr_flag",    32'(overrun), 32'h1);
        check("ovr_rdy",     32'(rdy),     32'h1);
        ack();
        check("ovr_ack_rdy", 32'(rdy),     32'h0);
        check("ovr_ack_flag", 32'(overrun), 32'h0);

        // Acknowledge coinciding with the load: load wins, no overrun.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        check("coinc_dout", 32'(dout),    32'h22);
        check("coinc_rdy",  32'(rdy),     32'h1);
        check("coinc_ovr",  32'(overrun), 32'h0);

        // Asynchronous reset in the middle of data bit 4 of 0xF0.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        rx = 1'b1;
        ticks(8);
        check("mid_busy", 32'(rx_busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_dout",  32'(dout),       32'h0);
        check("mid_reset_rdy",   32'(rdy),        32'h0);
        check("mid_reset_busy",  32'(rx_busy),    32'h0);
        check("mid_reset_fe",    32'(frame_err),  32'h0);
        check("mid_reset_ovr",   32'(overrun),    32'h0);
        check("mid_reset_pe",    32'(parity_err), 32'h0);
        @(negedge system_clk);
        reset = 1'b0;
        ticks(16);
        check("post_reset_busy", 32'(rx_busy), 32'h0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("post_reset_dout", 32'(dout), 32'h5A);
        check("post_reset_rdy",  32'(rdy),  32'h1);
        ack();

`ifdef UART_RX_PARITY_EN
        bad_parity = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_ok_pe",   32'(pe_count), 32'h0);
        check("par_ok_rdy",  32'(rdy),      32'h1);
        check("par_ok_dout", 32'(dout),     32'h07);
        ack();
        bad_parity = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        bad_parity = 1'b0;
        check("par_bad_pe",   32'(pe_count), 32'h1);
        check("par_bad_rdy",  32'(rdy),      32'h1);
        check("par_bad_dout", 32'(dout),     32'h07);
        ack();
`else
        check("no_parity_pulses", 32'(pe_count), 32'h0);
`endif
        check("total_frame_errs", 32'(fe_count), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
